rgb_to_yuv_encoder: RTL and testbench



---
 rtl/encoder_pkg.sv | 85 ++++++++
 rtl/rgb_pair_to_yuv.sv | 48 ++++
 rtl/rgb_to_yuv_encoder.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_rgb_to_yuv_encoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg
// Shared definitions for the RGB -> YUV encoder milestone:
//   - E_state_type : encoder sequencing states (one state per SRAM cycle)
//   - BT.601 colour-space coefficients, offsets and rounding constant
//   - default SRAM base addresses and frame size
//   - clip_u8 / csc helpers used by the pixel-pair converter
// -----------------------------------------------------------------------------
package encoder_pkg;

    // Each state names the cycle in which its SRAM outputs are on the pins.
    typedef enum logic [3:0] {
        S_E_IDLE = 4'd0,
        S_RD0    = 4'd1,
        S_RD1    = 4'd2,
        S_RD2    = 4'd3,
        S_RD3    = 4'd4,
        S_RD4    = 4'd5,
        S_RD5    = 4'd6,
        S_WYA    = 4'd7,
        S_WAIT   = 4'd8,
        S_CONVB  = 4'd9,
        S_WYB    = 4'd10,
        S_WU     = 4'd11,
        S_WV     = 4'd12,
        S_E_FIN  = 4'd13
    } E_state_type;

    // BT.601 coefficients (scaled by 256).
    localparam logic signed [31:0] C_Y_R = 32'sd66;
    localparam logic signed [31:0] C_Y_G = 32'sd129;
    localparam logic signed [31:0] C_Y_B = 32'sd25;
    localparam logic signed [31:0] C_U_R = -32'sd38;
    localparam logic signed [31:0] C_U_G = -32'sd74;
    localparam logic signed [31:0] C_U_B = 32'sd112;
    localparam logic signed [31:0] C_V_R = 32'sd112;
    localparam logic signed [31:0] C_V_G = -32'sd94;
    localparam logic signed [31:0] C_V_B = -32'sd18;

    localparam logic signed [31:0] Y_OFFSET  = 32'sd16;
    localparam logic signed [31:0] UV_OFFSET = 32'sd128;
    localparam logic signed [31:0] ROUND     = 32'sd128;

    // Default memory map (word addresses).
    localparam logic [17:0] Y_BASE_DEF     = 18'd0;
    localparam logic [17:0] U_BASE_DEF     = 18'd38400;
    localparam logic [17:0] V_BASE_DEF     = 18'd57600;
    localparam logic [17:0] RGB_BASE_DEF   = 18'd146944;
    localparam int          NUM_GROUPS_DEF = 19200;

    // Group counter is wide enough for a full 320x240 frame.
    localparam int GROUP_W = 15;

    // Saturate a signed intermediate into the 0..255 pixel range.
    function automatic logic [7:0] clip_u8(input logic signed [31:0] val);
        logic [7:0] res;
        if (val < 32'sd0) begin
            res = 8'd0;
        end else if (val > 32'sd255) begin
            res = 8'd255;
        end else begin
            res = val[7:0];
        end
        return res;
    endfunction

    // One colour-space component: ((cr*R + cg*G + cb*B + 128) >>> 8) + off, clipped.
    function automatic logic [7:0] csc(
        input logic        [7:0]  r,
        input logic        [7:0]  g,
        input logic        [7:0]  b,
        input logic signed [31:0] cr,
        input logic signed [31:0] cg,
        input logic signed [31:0] cb,
        input logic signed [31:0] off
    );
        logic signed [31:0] acc;
        acc = cr * $signed({24'd0, r})
            + cg * $signed({24'd0, g})
            + cb * $signed({24'd0, b})
            + ROUND;
        return clip_u8((acc >>> 5'd8) + off);
    endfunction

endpackage

// File: rtl/rgb_pair_to_yuv.sv
// -----------------------------------------------------------------------------
// rgb_pair_to_yuv
// Combinational BT.601 conversion of two horizontally adjacent RGB pixels.
// Produces both luma samples and one chroma pair decimated by averaging.
// Ports:
//   r_even,g_even,b_even  in  8  first (even) pixel
//   r_odd, g_odd, b_odd   in  8  second (odd) pixel
//   y_even, y_odd         out 8  clipped luma of each pixel
//   u_avg, v_avg          out 8  (U_even+U_odd+1)>>1, same for V
// -----------------------------------------------------------------------------
module rgb_pair_to_yuv
    import encoder_pkg::*;
(
    input  logic [7:0] r_even,
    input  logic [7:0] g_even,
    input  logic [7:0] b_even,
    input  logic [7:0] r_odd,
    input  logic [7:0] g_odd,
    input  logic [7:0] b_odd,
    output logic [7:0] y_even,
    output logic [7:0] y_odd,
    output logic [7:0] u_avg,
    output logic [7:0] v_avg
);

    logic [7:0] u_even_s;
    logic [7:0] u_odd_s;
    logic [7:0] v_even_s;
    logic [7:0] v_odd_s;
    logic [8:0] u_sum_s;
    logic [8:0] v_sum_s;

    // Per-pixel conversion and 9-bit rounded chroma average.
    always_comb begin
        y_even   = csc(r_even, g_even, b_even, C_Y_R, C_Y_G, C_Y_B, Y_OFFSET);
        y_odd    = csc(r_odd,  g_odd,  b_odd,  C_Y_R, C_Y_G, C_Y_B, Y_OFFSET);
        u_even_s = csc(r_even, g_even, b_even, C_U_R, C_U_G, C_U_B, UV_OFFSET);
        u_odd_s  = csc(r_odd,  g_odd,  b_odd,  C_U_R, C_U_G, C_U_B, UV_OFFSET);
        v_even_s = csc(r_even, g_even, b_even, C_V_R, C_V_G, C_V_B, UV_OFFSET);
        v_odd_s  = csc(r_odd,  g_odd,  b_odd,  C_V_R, C_V_G, C_V_B, UV_OFFSET);
        // 255+255+1 fits in 9 bits; dropping bit 0 is the divide by two.
        u_sum_s  = {1'b0, u_even_s} + {1'b0, u_odd_s} + 9'd1;
        v_sum_s  = {1'b0, v_even_s} + {1'b0, v_odd_s} + 9'd1;
        u_avg    = u_sum_s[8:1];
        v_avg    = v_sum_s[8:1];
    end

endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// -----------------------------------------------------------------------------
// rgb_to_yuv_encoder
// Reads a packed RGB frame from single-port SRAM, converts to BT.601 YUV with
// 2:1 horizontal chroma decimation and writes Y, U and V planes back in the
// layout the decoder consumes. Works on 4-pixel groups in a fixed 12-cycle
// loop, started by E_start and finished with a one-cycle E_done.
// Ports:
//   CLOCK_50_I       in   1  clock
//   resetn           in   1  asynchronous active-low reset
//   E_start          in   1  start pulse, only honoured when idle
//   E_busy           out  1  frame in progress
//   E_done           out  1  one-cycle pulse after the final V write
//   SRAM_address     out 18  registered word address
//   SRAM_write_data  out 16  registered write data
//   SRAM_we_n        out  1  registered write enable, active low
//   SRAM_read_data   in  16  read data (2-cycle latency)
// -----------------------------------------------------------------------------
module rgb_to_yuv_encoder
    import encoder_pkg::*;
#(
    parameter logic [17:0] Y_BASE     = Y_BASE_DEF,
    parameter logic [17:0] U_BASE     = U_BASE_DEF,
    parameter logic [17:0] V_BASE     = V_BASE_DEF,
    parameter logic [17:0] RGB_BASE   = RGB_BASE_DEF,
    parameter int          NUM_GROUPS = NUM_GROUPS_DEF
) (
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        E_start,
    output logic        E_busy,
    output logic        E_done,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data
);

    localparam logic [GROUP_W-1:0] LAST_GROUP = GROUP_W'(NUM_GROUPS - 1);

    E_state_type        state_r;
    E_state_type        next_state_s;

    logic               start_accept_s;
    logic               is_last_s;
    logic               next_is_read_s;
    logic [17:0]        rgb_cur_s;

    logic [17:0]        rgb_addr_r;
    logic [17:0]        y_addr_r;
    logic [17:0]        u_addr_r;
    logic [17:0]        v_addr_r;
    logic [GROUP_W-1:0] group_r;

    // Captured RGB words: pair A = w0..w2, pair B = w3..w5.
    logic [15:0]        pa_w0_r;
    logic [15:0]        pa_w1_r;
    logic [15:0]        pa_w2_r;
    logic [15:0]        pb_w0_r;
    logic [15:0]        pb_w1_r;
    logic [15:0]        pb_w2_r;

    logic [15:0]        cw0_s;
    logic [15:0]        cw1_s;
    logic [15:0]        cw2_s;

    logic [7:0]         y_even_s;
    logic [7:0]         y_odd_s;
    logic [7:0]         u_avg_s;
    logic [7:0]         v_avg_s;

    logic [7:0]         u_a_r;
    logic [7:0]         v_a_r;
    logic [7:0]         u_b_r;
    logic [7:0]         v_b_r;

    logic [17:0]        addr_next_s;
    logic [15:0]        data_next_s;
    logic               we_n_next_s;
    logic               busy_next_s;
    logic               done_next_s;

    // Status decode shared by the FSM, counters and output logic.
    always_comb begin
        start_accept_s = (state_r == S_E_IDLE) && E_start;
        is_last_s      = (group_r == LAST_GROUP);
        // The first read of a frame bypasses the counter so it can issue the
        // cycle right after start while the counter reloads in parallel.
        if (state_r == S_E_IDLE) begin
            rgb_cur_s = RGB_BASE;
        end else begin
            rgb_cur_s = rgb_addr_r;
        end
        case (next_state_s)
            S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5: next_is_read_s = 1'b1;
            default:                                  next_is_read_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_E_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: fixed 12-cycle group loop.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_E_IDLE: begin
                if (E_start) begin
                    next_state_s = S_RD0;
                end else begin
                    next_state_s = S_E_IDLE;
                end
            end
            S_RD0:   next_state_s = S_RD1;
            S_RD1:   next_state_s = S_RD2;
            S_RD2:   next_state_s = S_RD3;
            S_RD3:   next_state_s = S_RD4;
            S_RD4:   next_state_s = S_RD5;
            S_RD5:   next_state_s = S_WYA;
            S_WYA:   next_state_s = S_WAIT;
            S_WAIT:  next_state_s = S_CONVB;
            S_CONVB: next_state_s = S_WYB;
            S_WYB:   next_state_s = S_WU;
            S_WU:    next_state_s = S_WV;
            S_WV: begin
                if (is_last_s) begin
                    next_state_s = S_E_FIN;
                end else begin
                    next_state_s = S_RD0;
                end
            end
            S_E_FIN: next_state_s = S_E_IDLE;
            default: next_state_s = S_E_IDLE;
        endcase
    end

    // Output logic: computes the SRAM/handshake values for the state being entered.
    always_comb begin
        addr_next_s = SRAM_address;
        data_next_s = SRAM_write_data;
        we_n_next_s = 1'b1;
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (next_state_s)
            S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5: begin
                addr_next_s = rgb_cur_s;
                busy_next_s = 1'b1;
            end
            // Luma writes take the converter output directly; it is driven
            // by pair A in S_RD5 and by pair B in S_CONVB.
            S_WYA, S_WYB: begin
                addr_next_s = y_addr_r;
                data_next_s = {y_even_s, y_odd_s};
                we_n_next_s = 1'b0;
                busy_next_s = 1'b1;
            end
            S_WAIT, S_CONVB: begin
                busy_next_s = 1'b1;
            end
            S_WU: begin
                addr_next_s = u_addr_r;
                data_next_s = {u_a_r, u_b_r};
                we_n_next_s = 1'b0;
                busy_next_s = 1'b1;
            end
            S_WV: begin
                addr_next_s = v_addr_r;
                data_next_s = {v_a_r, v_b_r};
                we_n_next_s = 1'b0;
                busy_next_s = 1'b1;
            end
            S_E_FIN: begin
                done_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase
    end

    // Registered SRAM and handshake outputs.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            SRAM_address    <= 18'd0;
            SRAM_write_data <= 16'd0;
            SRAM_we_n       <= 1'b1;
            E_busy          <= 1'b0;
            E_done          <= 1'b0;
        end else begin
            SRAM_address    <= addr_next_s;
            SRAM_write_data <= data_next_s;
            SRAM_we_n       <= we_n_next_s;
            E_busy          <= busy_next_s;
            E_done          <= done_next_s;
        end
    end

    // Address and group counters; reloaded on every accepted start.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            rgb_addr_r <= RGB_BASE;
            y_addr_r   <= Y_BASE;
            u_addr_r   <= U_BASE;
            v_addr_r   <= V_BASE;
            group_r    <= '0;
        end else begin
            if (next_is_read_s) begin
                rgb_addr_r <= rgb_cur_s + 18'd1;
            end else begin
                rgb_addr_r <= rgb_addr_r;
            end

            if (start_accept_s) begin
                y_addr_r <= Y_BASE;
            end else if ((next_state_s == S_WYA) || (next_state_s == S_WYB)) begin
                y_addr_r <= y_addr_r + 18'd1;
            end else begin
                y_addr_r <= y_addr_r;
            end

            if (start_accept_s) begin
                u_addr_r <= U_BASE;
            end else if (next_state_s == S_WU) begin
                u_addr_r <= u_addr_r + 18'd1;
            end else begin
                u_addr_r <= u_addr_r;
            end

            if (start_accept_s) begin
                v_addr_r <= V_BASE;
            end else if (next_state_s == S_WV) begin
                v_addr_r <= v_addr_r + 18'd1;
            end else begin
                v_addr_r <= v_addr_r;
            end

            if (start_accept_s) begin
                group_r <= '0;
            end else if (state_r == S_WV) begin
                group_r <= group_r + 1'b1;
            end else begin
                group_r <= group_r;
            end
        end
    end

    // Read-data capture: data for a read issued in cycle c lands at the end of c+2.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            pa_w0_r <= 16'd0;
            pa_w1_r <= 16'd0;
            pa_w2_r <= 16'd0;
            pb_w0_r <= 16'd0;
            pb_w1_r <= 16'd0;
            pb_w2_r <= 16'd0;
        end else begin
            case (state_r)
                S_RD2:   pa_w0_r <= SRAM_read_data;
                S_RD3:   pa_w1_r <= SRAM_read_data;
                S_RD4:   pa_w2_r <= SRAM_read_data;
                S_RD5:   pb_w0_r <= SRAM_read_data;
                S_WYA:   pb_w1_r <= SRAM_read_data;
                S_WAIT:  pb_w2_r <= SRAM_read_data;
                default: pa_w0_r <= pa_w0_r;
            endcase
        end
    end

    // Converter input select: pair B only while it is being converted.
    always_comb begin
        if (state_r == S_CONVB) begin
            cw0_s = pb_w0_r;
            cw1_s = pb_w1_r;
            cw2_s = pb_w2_r;
        end else begin
            cw0_s = pa_w0_r;
            cw1_s = pa_w1_r;
            cw2_s = pa_w2_r;
        end
    end

    // Word layout: {R0,G0} {B0,R1} {G1,B1}.
    rgb_pair_to_yuv u_conv (
        .r_even (cw0_s[15:8]),
        .g_even (cw0_s[7:0]),
        .b_even (cw1_s[15:8]),
        .r_odd  (cw1_s[7:0]),
        .g_odd  (cw2_s[15:8]),
        .b_odd  (cw2_s[7:0]),
        .y_even (y_even_s),
        .y_odd  (y_odd_s),
        .u_avg  (u_avg_s),
        .v_avg  (v_avg_s)
    );

    // Hold decimated chroma of both pairs until the U/V writes at the group end.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            u_a_r <= 8'd0;
            v_a_r <= 8'd0;
            u_b_r <= 8'd0;
            v_b_r <= 8'd0;
        end else begin
            case (state_r)
                S_RD5: begin
                    u_a_r <= u_avg_s;
                    v_a_r <= v_avg_s;
                end
                S_CONVB: begin
                    u_b_r <= u_avg_s;
                    v_b_r <= v_avg_s;
                end
                default: begin
                    u_a_r <= u_a_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// -----------------------------------------------------------------------------
// tb_rgb_to_yuv_encoder
// Directed bench with an SRAM model: a table of 4-pixel groups with
// hand-computed Y/U/V words, cycle timing of the first groups, busy/done
// handshake, start while busy / during done, and reset mid-group.
// -----------------------------------------------------------------------------
module tb_rgb_to_yuv_encoder;

    localparam int          N        = 12;
    localparam logic [17:0] Y_BASE   = 18'd0;
    localparam logic [17:0] U_BASE   = 18'd38400;
    localparam logic [17:0] V_BASE   = 18'd57600;
    localparam logic [17:0] RGB_BASE = 18'd146944;

    typedef struct packed {
        logic [95:0] px;   // four {R,G,B} pixels, first pixel in the top bits
        logic [15:0] y01;
        logic [15:0] y23;
        logic [15:0] u;
        logic [15:0] v;
    } vec_t;

    logic        CLOCK_50_I;
    logic        resetn;
    logic        E_start;
    logic        E_busy;
    logic        E_done;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;

    logic [15:0] mem [0:262143];
    logic [17:0] rd_a1;
    logic [17:0] rd_a2;
    logic        tb_we;
    logic [17:0] tb_addr;
    logic [15:0] tb_data;

    vec_t        vecs [5];
    int          checks;
    int          errors;
    int          cyc;
    int          busy_cnt;
    int          done_cnt;
    int          last_w_cyc;
    logic [17:0] last_w_addr;

    rgb_to_yuv_encoder #(
        .Y_BASE     (Y_BASE),
        .U_BASE     (U_BASE),
        .V_BASE     (V_BASE),
        .RGB_BASE   (RGB_BASE),
        .NUM_GROUPS (N)
    ) dut (
        .CLOCK_50_I      (CLOCK_50_I),
        .resetn          (resetn),
        .E_start         (E_start),
        .E_busy          (E_busy),
        .E_done          (E_done),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data)
    );

    initial begin
        CLOCK_50_I = 1'b0;
        forever #10 CLOCK_50_I = ~CLOCK_50_I;
    end

    // SRAM model: writes commit at the edge ending the we_n=0 cycle; reads
    // return data two cycles after the address is presented.
    always @(posedge CLOCK_50_I) begin
        if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end else if (!SRAM_we_n) begin
            mem[SRAM_address] <= SRAM_write_data;
        end
        rd_a1 <= SRAM_address;
        rd_a2 <= rd_a1;
        cyc   <= cyc + 1;
    end
    assign SRAM_read_data = mem[rd_a2];

    // Activity monitor sampled on the falling edge.
    always @(negedge CLOCK_50_I) begin
        if (resetn) begin
            if (!SRAM_we_n) begin
                last_w_addr <= SRAM_address;
                last_w_cyc  <= cyc;
            end
            if (E_busy) busy_cnt <= busy_cnt + 1;
            if (E_done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tb_write(input logic [17:0] a, input logic [15:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(negedge CLOCK_50_I);
        tb_we   = 1'b0;
    endtask

    task automatic preload();
        vec_t        v;
        logic [23:0] p0, p1, p2, p3;
        int          base;
        for (int g = 0; g < N; g++) begin
            v    = vecs[g % 5];
            p0   = v.px[95:72];
            p1   = v.px[71:48];
            p2   = v.px[47:24];
            p3   = v.px[23:0];
            base = int'(RGB_BASE) + 6 * g;
            tb_write(18'(base + 0), {p0[23:16], p0[15:8]});
            tb_write(18'(base + 1), {p0[7:0],   p1[23:16]});
            tb_write(18'(base + 2), {p1[15:8],  p1[7:0]});
            tb_write(18'(base + 3), {p2[23:16], p2[15:8]});
            tb_write(18'(base + 4), {p2[7:0],   p3[23:16]});
            tb_write(18'(base + 5), {p3[15:8],  p3[7:0]});
        end
    endtask

    task automatic verify_mem(input string tag);
        vec_t v;
        for (int g = 0; g < N; g++) begin
            v = vecs[g % 5];
            chk($sformatf("%s_y01_g%0d", tag, g), {16'd0, mem[int'(Y_BASE) + 2 * g]},     {16'd0, v.y01});
            chk($sformatf("%s_y23_g%0d", tag, g), {16'd0, mem[int'(Y_BASE) + 2 * g + 1]}, {16'd0, v.y23});
            chk($sformatf("%s_u_g%0d",   tag, g), {16'd0, mem[int'(U_BASE) + g]},         {16'd0, v.u});
            chk($sformatf("%s_v_g%0d",   tag, g), {16'd0, mem[int'(V_BASE) + g]},         {16'd0, v.v});
        end
    endtask

    // Expected bus activity at cycle k of the frame (k=0 is the first busy cycle).
    task automatic timing_check(input int k);
        int m, grp;
        m   = k % 12;
        grp = k / 12;
        if (m < 6) begin
            chk($sformatf("rd_addr_c%0d", k), {14'd0, SRAM_address}, int'(RGB_BASE) + grp * 6 + m);
            chk($sformatf("rd_we_c%0d", k), {31'd0, SRAM_we_n}, 32'd1);
        end else if ((m == 7) || (m == 8)) begin
            chk($sformatf("idle_we_c%0d", k), {31'd0, SRAM_we_n}, 32'd1);
        end else begin
            chk($sformatf("wr_we_c%0d", k), {31'd0, SRAM_we_n}, 32'd0);
            case (m)
                6:       chk($sformatf("wr_addr_c%0d", k), {14'd0, SRAM_address}, int'(Y_BASE) + 2 * grp);
                9:       chk($sformatf("wr_addr_c%0d", k), {14'd0, SRAM_address}, int'(Y_BASE) + 2 * grp + 1);
                10:      chk($sformatf("wr_addr_c%0d", k), {14'd0, SRAM_address}, int'(U_BASE) + grp);
                default: chk($sformatf("wr_addr_c%0d", k), {14'd0, SRAM_address}, int'(V_BASE) + grp);
            endcase
        end
    endtask

    task automatic run_frame(input bit first);
        int k, t0, busy0, done0;
        @(negedge CLOCK_50_I);
        busy0   = busy_cnt;
        done0   = done_cnt;
        E_start = 1'b1;
        @(negedge CLOCK_50_I);
        E_start = 1'b0;
        t0      = cyc;
        chk("c0_busy", {31'd0, E_busy}, 32'd1);
        chk("c0_addr", {14'd0, SRAM_address}, {14'd0, RGB_BASE});
        k = 0;
        while ((E_done !== 1'b1) && (k < 12 * N + 64)) begin
            if (first && (k < 13)) timing_check(k);
            // Start pulse in the middle of group 3 must be ignored.
            if (first && (k == 40)) E_start = 1'b1;
            else                    E_start = 1'b0;
            @(negedge CLOCK_50_I);
            k++;
        end
        E_start = 1'b0;
        chk("done_seen", {31'd0, E_done}, 32'd1);
        chk("done_cycle", k, 12 * N);
        chk("last_w_addr", {14'd0, last_w_addr}, int'(V_BASE) + N - 1);
        chk("last_w_cyc", last_w_cyc, t0 + 12 * N - 1);
        // Start coincident with the done cycle is not accepted.
        if (first) E_start = 1'b1;
        @(negedge CLOCK_50_I);
        E_start = 1'b0;
        chk("after_done_busy", {31'd0, E_busy}, 32'd0);
        chk("after_done_we", {31'd0, SRAM_we_n}, 32'd1);
        chk("after_done_done", {31'd0, E_done}, 32'd0);
        @(negedge CLOCK_50_I);
        chk("idle_busy", {31'd0, E_busy}, 32'd0);
        chk("done_pulses", done_cnt - done0, 32'd1);
        chk("busy_cycles", busy_cnt - busy0, 12 * N);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        busy_cnt = 0;
        done_cnt = 0;
        resetn   = 1'b0;
        E_start  = 1'b0;
        tb_we    = 1'b0;
        tb_addr  = 18'd0;
        tb_data  = 16'd0;

        vecs[0] = '{px: {24'h000000, 24'h000000, 24'h000000, 24'h000000},
                    y01: 16'h1010, y23: 16'h1010, u: 16'h8080, v: 16'h8080};
        vecs[1] = '{px: {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF},
                    y01: 16'hEBEB, y23: 16'hEBEB, u: 16'h8080, v: 16'h8080};
        vecs[2] = '{px: {24'hFF0000, 24'hFF0000, 24'hFF0000, 24'h000000},
                    y01: 16'h5252, y23: 16'h5210, u: 16'h5A6D, v: 16'hF0B8};
        vecs[3] = '{px: {24'h00FF00, 24'h00FF00, 24'h0000FF, 24'h0000FF},
                    y01: 16'h9090, y23: 16'h2929, u: 16'h36F0, v: 16'h226E};
        vecs[4] = '{px: {24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h000000},
                    y01: 16'h9029, y23: 16'hEB10, u: 16'h9380, v: 16'h4880};

        repeat (3) @(negedge CLOCK_50_I);
        chk("rst_we_n", {31'd0, SRAM_we_n}, 32'd1);
        chk("rst_addr", {14'd0, SRAM_address}, 32'd0);
        chk("rst_data", {16'd0, SRAM_write_data}, 32'd0);
        chk("rst_busy", {31'd0, E_busy}, 32'd0);
        chk("rst_done", {31'd0, E_done}, 32'd0);

        preload();
        resetn = 1'b1;
        @(negedge CLOCK_50_I);
        chk("idle_no_start_busy", {31'd0, E_busy}, 32'd0);

        run_frame(1'b1);
        verify_mem("f1");

        // Mark group 10 output words, then reset during its cycle c4.
        tb_write(Y_BASE + 18'd20, 16'hDEAD);
        tb_write(Y_BASE + 18'd21, 16'hDEAD);
        tb_write(U_BASE + 18'd10, 16'hDEAD);
        tb_write(V_BASE + 18'd10, 16'hDEAD);
        E_start = 1'b1;
        @(negedge CLOCK_50_I);
        E_start = 1'b0;
        repeat (124) @(negedge CLOCK_50_I);
        chk("pre_reset_busy", {31'd0, E_busy}, 32'd1);
        chk("pre_reset_addr", {14'd0, SRAM_address}, int'(RGB_BASE) + 64);
        resetn = 1'b0;
        #1;
        chk("mid_rst_we_n", {31'd0, SRAM_we_n}, 32'd1);
        chk("mid_rst_addr", {14'd0, SRAM_address}, 32'd0);
        chk("mid_rst_data", {16'd0, SRAM_write_data}, 32'd0);
        chk("mid_rst_busy", {31'd0, E_busy}, 32'd0);
        repeat (30) @(negedge CLOCK_50_I);
        chk("no_flush_y20", {16'd0, mem[int'(Y_BASE) + 20]}, 32'h0000DEAD);
        chk("no_flush_y21", {16'd0, mem[int'(Y_BASE) + 21]}, 32'h0000DEAD);
        chk("no_flush_u10", {16'd0, mem[int'(U_BASE) + 10]}, 32'h0000DEAD);
        chk("no_flush_v10", {16'd0, mem[int'(V_BASE) + 10]}, 32'h0000DEAD);
        resetn = 1'b1;
        @(negedge CLOCK_50_I);
        chk("post_rst_busy", {31'd0, E_busy}, 32'd0);

        run_frame(1'b0);
        verify_mem("f2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
